// File: rtl/ipmred_pkg.sv
// Shared types and sizing helpers for the IPM-RED setup path (rand collector, setup, encoding).
package ipmred_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Bytes per rand word: one byte for each of L1[i] and L2[i], i = 2..V-1.
  function automatic int unsigned nb(input int unsigned v);
    return 2 * (v - 2);
  endfunction

  function automatic int unsigned rand_w(input int unsigned v);
    return 16 * (v - 2);
  endfunction

endpackage

// File: rtl/ipmred_rand_collector.sv
// Collects nb(V) bytes from a valid/ready random source into one held rand word.
// Optional zero-byte rejection with a saturating counter under IPMRED_REJECT_ZERO_EN.
// The packed word port is named rand_data because "rand" is a reserved word in SystemVerilog.
module ipmred_rand_collector
  import ipmred_pkg::*;
#(
  parameter int unsigned V = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BYTE_W-1:0]     in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [rand_w(V)-1:0]  rand_data,
  output logic                  rand_valid,
  input  logic                  rand_ack,
  output logic                  busy,
  output logic [7:0]            reject_cnt
);

  localparam int unsigned NB = nb(V);
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

  if (V < 3) begin : g_bad_v
    $error("ipmred_rand_collector: V must be >= 3");
  end

  state_e        state;
  logic [IW-1:0] idx;
  logic          xfer;
  logic          store;

  assign xfer = in_valid & in_ready;

`ifdef IPMRED_REJECT_ZERO_EN
  // Zero bytes complete the handshake but never reach the word, keeping L[i] nonzero.
  assign store = xfer & (in_byte != 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      reject_cnt <= 8'h00;
    end else if (xfer && (in_byte == 8'h00) && (reject_cnt != 8'hFF)) begin
      reject_cnt <= reject_cnt + 8'd1;
    end
  end
`else
  assign store      = xfer;
  assign reject_cnt = 8'h00;
`endif

  // FSM, byte index and packing register; all outputs registered with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      rand_data  <= '0;
      rand_valid <= 1'b0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FILL;
            idx      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FILL: begin
          if (store) begin
            for (int unsigned k = 0; k < NB; k++) begin
              if (idx == IW'(k)) rand_data[BYTE_W*k +: BYTE_W] <= in_byte;
            end
            if (idx == IW'(NB - 1)) begin
              state      <= HOLD;
              in_ready   <= 1'b0;
              rand_valid <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        HOLD: begin
          if (rand_ack) begin
            rand_valid <= 1'b0;
            // Back-to-back request skips IDLE so the next session starts a cycle earlier.
            if (start) begin
              state    <= FILL;
              idx      <= '0;
              in_ready <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          idx        <= '0;
          rand_valid <= 1'b0;
          in_ready   <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipmred_rand_collector.sv
// Self-checking bench for ipmred_rand_collector (V=8): behavioural model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_ipmred_rand_collector;
  import ipmred_pkg::*;

  localparam int unsigned V  = 8;
  localparam int unsigned NB = 12;
  localparam int unsigned RW = 96;
`ifdef IPMRED_REJECT_ZERO_EN
  localparam bit REJ = 1'b1;
`else
  localparam bit REJ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] rand_data;
  logic          rand_valid;
  logic          rand_ack = 1'b0;
  logic          busy;
  logic [7:0]    reject_cnt;

  ipmred_rand_collector #(.V(V)) dut (
    .clk(clk), .rst(rst), .start(start), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .rand_data(rand_data), .rand_valid(rand_valid),
    .rand_ack(rand_ack), .busy(busy), .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: session phase, bytes stored so far, word image, reject count.
  logic [RW-1:0] m_word = '0;
  bit m_busy = 0, m_fill = 0, m_hold = 0;
  int m_cnt = 0, m_rej = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_word = '0; m_busy = 0; m_fill = 0; m_hold = 0; m_cnt = 0; m_rej = 0;
    end else if (!m_busy) begin
      if (start) begin m_busy = 1; m_fill = 1; m_cnt = 0; end
    end else if (m_fill) begin
      if (in_valid) begin
        if (REJ && in_byte == 8'h00) begin
          if (m_rej < 255) m_rej++;
        end else begin
          m_word[8*m_cnt +: 8] = in_byte;
          m_cnt++;
          if (m_cnt == NB) begin m_fill = 0; m_hold = 1; end
        end
      end
    end else if (rand_ack) begin
      m_hold = 0;
      if (start) begin m_fill = 1; m_cnt = 0; end
      else m_busy = 0;
    end
    #1;
    check("model_rand", rand_data, m_word);
    check("model_rand_valid", RW'(rand_valid), RW'(m_hold));
    check("model_in_ready", RW'(in_ready), RW'(m_fill));
    check("model_busy", RW'(busy), RW'(m_busy));
    check("model_reject_cnt", RW'(reject_cnt), RW'(m_rej));
  end

  // Drives one session: optional start, then the byte queue with an optional stall window.
  task automatic run_word(input logic [7:0] q[$], input bit do_start, input int stall_at,
                          input int stall_len, output int lat, output logic [RW-1:0] word);
    int i = 0, stalled = 0, t0 = 0;
    bit xf;
    lat = -1;
    word = '0;
    @(negedge clk);
    t0 = cyc;
    if (do_start) start = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) begin
        @(negedge clk);
        start = 1'b0;
        if (rand_valid) begin lat = cyc - t0; word = rand_data; break; end
      end
      if (i < q.size() && !(i == stall_at && stalled < stall_len)) begin
        in_valid = 1'b1; in_byte = q[i];
      end else begin
        in_valid = 1'b0;
        if (i == stall_at && in_ready) stalled++;
      end
      xf = in_valid && in_ready;
      @(posedge clk);
      if (xf) i++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (lat < 0) check("session_timeout", RW'(0), RW'(1));
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1; start = 1'b0; in_valid = 1'b0; rand_ack = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic ack_word();
    @(negedge clk); rand_ack = 1'b1;
    @(negedge clk); rand_ack = 1'b0;
  endtask

  localparam logic [RW-1:0] W_SEQ   = 96'h0C0B0A090807060504030201;
  localparam logic [RW-1:0] W_FRESH = 96'h2C2B2A292827262524232221;

  initial begin
    logic [7:0] q[$];
    logic [7:0] qf[$];
    logic [7:0] qz[$];
    logic [RW-1:0] w;
    int lat;

    for (int k = 0; k < NB; k++) begin
      q.push_back(8'(k + 1));
      qf.push_back(8'(k + 8'h21));
    end
    qz = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h05,
           8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};

    repeat (2) @(negedge clk);
    check("reset_rand", rand_data, '0);
    check("reset_valid", RW'(rand_valid), RW'(0));
    check("reset_ready", RW'(in_ready), RW'(0));
    check("reset_busy", RW'(busy), RW'(0));
    check("reset_rej", RW'(reject_cnt), RW'(0));
    rst = 1'b0;

    // Straight stream.
    run_word(q, 1'b1, -1, 0, lat, w);
    check("plain_latency", RW'(lat), RW'(13));
    check("plain_word", w, W_SEQ);
    ack_word();
    check("ack_to_idle_busy", RW'(busy), RW'(0));
    check("ack_keeps_word", rand_data, W_SEQ);

    // Three stall cycles after byte 5.
    run_word(q, 1'b1, 5, 3, lat, w);
    check("stall_latency", RW'(lat), RW'(16));
    check("stall_word", w, W_SEQ);

    // Hold without ack while the source keeps offering bytes.
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_byte = 8'($urandom_range(1, 255));
      @(negedge clk);
      check("hold_ready", RW'(in_ready), RW'(0));
      check("hold_word", rand_data, W_SEQ);
    end
    in_valid = 1'b0;
    ack_word();
    check("hold_ack_idle", RW'(busy), RW'(0));

    // Ack and start together go straight back to FILL.
    run_word(qf, 1'b1, -1, 0, lat, w);
    check("fresh_word", w, W_FRESH);
    @(negedge clk); rand_ack = 1'b1; start = 1'b1;
    @(negedge clk); rand_ack = 1'b0; start = 1'b0;
    check("direct_fill_ready", RW'(in_ready), RW'(1));
    check("direct_fill_busy", RW'(busy), RW'(1));
    check("direct_fill_valid", RW'(rand_valid), RW'(0));
    run_word(q, 1'b0, -1, 0, lat, w);
    check("direct_fill_word", w, W_SEQ);
    ack_word();

    // Zero bytes in the stream.
    pulse_rst();
    run_word(qz, 1'b1, -1, 0, lat, w);
`ifdef IPMRED_REJECT_ZERO_EN
    check("zero_latency", RW'(lat), RW'(16));
    check("zero_word", w, W_SEQ);
    check("zero_rej", RW'(reject_cnt), RW'(3));
`else
    check("zero_latency", RW'(lat), RW'(13));
    check("zero_word", w, 96'h090807060504000300020001);
    check("zero_rej", RW'(reject_cnt), RW'(0));
`endif
    ack_word();

    // Reset mid-FILL after 6 bytes.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_byte = 8'(8'hA0 + k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    pulse_rst();
    check("rst_fill_rand", rand_data, '0);
    check("rst_fill_valid", RW'(rand_valid), RW'(0));
    check("rst_fill_busy", RW'(busy), RW'(0));
    run_word(qf, 1'b1, -1, 0, lat, w);
    check("rst_fill_fresh_lat", RW'(lat), RW'(13));
    check("rst_fill_fresh_word", w, W_FRESH);

    // Reset while holding.
    pulse_rst();
    check("rst_hold_rand", rand_data, '0);
    check("rst_hold_valid", RW'(rand_valid), RW'(0));
    check("rst_hold_busy", RW'(busy), RW'(0));
    run_word(q, 1'b1, -1, 0, lat, w);
    check("rst_hold_fresh_word", w, W_SEQ);
    ack_word();

`ifdef IPMRED_REJECT_ZERO_EN
    // Long run of zeros saturates the counter and never leaves FILL.
    pulse_rst();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      in_valid = 1'b1; in_byte = 8'h00;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("sat_rej", RW'(reject_cnt), RW'(8'hFF));
    check("sat_ready", RW'(in_ready), RW'(1));
    check("sat_valid", RW'(rand_valid), RW'(0));
`endif

    // Randomized traffic; the model checks every cycle.
    pulse_rst();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 399) == 0);
      start    = ($urandom_range(0, 3) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_byte  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      rand_ack = ($urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; rand_ack = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
